// File: rtl/tx_redundant.sv
// Buffers one upstream packet and retransmits it R times as
// [copy index, payload..., TRAILER] frames, each followed by an idle gap.
module tx_redundant #(
  parameter int          MAX_PAYLOAD = 64,
  parameter int          GAP_CYCLES  = 12,
  parameter logic [7:0]  TRAILER     = 8'hEF
) (
  input  logic       clk125MHz,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       en_in,
  input  logic [7:0] redundancy,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic       done,
  output logic       overflow,
  output logic       busy_drop
);

  // state        | meaning
  // IDLE         | waiting for first payload byte, in_ready high
  // CAPTURE      | storing payload bytes while en_in stays high
  // SEND_ID      | emitting the copy index byte
  // SEND_PAYLOAD | emitting buffered payload bytes 0..L-1
  // SEND_TRAILER | emitting TRAILER
  // GAP          | tx_enable low between copies / before done
  typedef enum logic [2:0] {
    IDLE, CAPTURE, SEND_ID, SEND_PAYLOAD, SEND_TRAILER, GAP
  } state_t;

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PAYLOAD);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

  state_t          state, state_nxt;
  logic [CW-1:0]   wr_cnt, wr_cnt_nxt;
  logic [CW-1:0]   len, len_nxt;
  logic [CW-1:0]   rd_cnt, rd_cnt_nxt;
  logic [7:0]      copy_idx, copy_idx_nxt;
  logic [7:0]      copies, copies_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            ovf_seen, ovf_seen_nxt;
  logic [7:0]      tx_data_nxt;
  logic            tx_enable_nxt, done_nxt, overflow_nxt, busy_drop_nxt;

  logic [7:0]      pkt_mem [MAX_PAYLOAD];
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wdata;

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    len_nxt       = len;
    rd_cnt_nxt    = rd_cnt;
    copy_idx_nxt  = copy_idx;
    copies_nxt    = copies;
    gap_cnt_nxt   = gap_cnt;
    ovf_seen_nxt  = ovf_seen;
    tx_data_nxt   = 8'h00;
    tx_enable_nxt = 1'b0;
    done_nxt      = 1'b0;
    overflow_nxt  = 1'b0;
    busy_drop_nxt = en_in && (state != IDLE) && (state != CAPTURE);
    mem_we        = 1'b0;
    mem_addr      = wr_cnt[AW-1:0];
    mem_wdata     = data_in;

    case (state)
      IDLE: begin
        if (en_in) begin
          mem_we       = 1'b1;
          mem_addr     = '0;
          wr_cnt_nxt   = CW'(1);
          copies_nxt   = (redundancy == 8'd0) ? 8'd1 : redundancy;
          ovf_seen_nxt = 1'b0;
          state_nxt    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (en_in) begin
          if (wr_cnt < MAX_CNT) begin
            mem_we     = 1'b1;
            wr_cnt_nxt = wr_cnt + CW'(1);
          end else if (!ovf_seen) begin
            overflow_nxt = 1'b1;
            ovf_seen_nxt = 1'b1;
          end
        end else begin
          len_nxt      = wr_cnt;
          copy_idx_nxt = 8'd1;
          state_nxt    = SEND_ID;
        end
      end
      SEND_ID: begin
        tx_enable_nxt = 1'b1;
        tx_data_nxt   = copy_idx;
        rd_cnt_nxt    = '0;
        state_nxt     = SEND_PAYLOAD;
      end
      SEND_PAYLOAD: begin
        tx_enable_nxt = 1'b1;
        tx_data_nxt   = pkt_mem[rd_cnt[AW-1:0]];
        rd_cnt_nxt    = rd_cnt + CW'(1);
        if (rd_cnt == len - CW'(1)) state_nxt = SEND_TRAILER;
      end
      SEND_TRAILER: begin
        tx_enable_nxt = 1'b1;
        tx_data_nxt   = TRAILER;
        // The final gap runs one edge longer so done lands after a full gap.
        gap_cnt_nxt   = (copy_idx < copies) ? GAP_LOAD : GAP_LAST;
        state_nxt     = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (copy_idx < copies) begin
            copy_idx_nxt = copy_idx + 8'd1;
            state_nxt    = SEND_ID;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      len       <= '0;
      rd_cnt    <= '0;
      copy_idx  <= '0;
      copies    <= '0;
      gap_cnt   <= '0;
      ovf_seen  <= 1'b0;
      tx_data   <= 8'h00;
      tx_enable <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      busy_drop <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      len       <= len_nxt;
      rd_cnt    <= rd_cnt_nxt;
      copy_idx  <= copy_idx_nxt;
      copies    <= copies_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ovf_seen  <= ovf_seen_nxt;
      tx_data   <= tx_data_nxt;
      tx_enable <= tx_enable_nxt;
      done      <= done_nxt;
      overflow  <= overflow_nxt;
      busy_drop <= busy_drop_nxt;
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (mem_we) pkt_mem[mem_addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_tx_redundant.sv
// Randomised bench for tx_redundant: a per-cycle expected output stream is
// built from the packet rules and compared against the DUT every cycle.
module tb_tx_redundant;
  localparam int         MAXP = 64;
  localparam int         GAP  = 12;
  localparam logic [7:0] TRL  = 8'hEF;

  logic       clk125MHz = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       en_in;
  logic [7:0] redundancy;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       done;
  logic       overflow;
  logic       busy_drop;

  tx_redundant #(.MAX_PAYLOAD(MAXP), .GAP_CYCLES(GAP), .TRAILER(TRL)) dut (
    .clk125MHz(clk125MHz), .reset(reset), .data_in(data_in), .en_in(en_in),
    .redundancy(redundancy), .in_ready(in_ready), .tx_data(tx_data),
    .tx_enable(tx_enable), .done(done), .overflow(overflow), .busy_drop(busy_drop)
  );

  always #4 clk125MHz = ~clk125MHz;

  typedef struct {
    logic       ir;
    logic       en;
    logic [7:0] d;
    logic       dn;
    logic       ov;
    logic       bd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mseq[$];
  int         checks = 0;
  int         failures = 0;
  int         fail_prints = 0;
  int         cyc = 0;
  int         n_done = 0, n_ovf = 0, n_busy = 0;
  bit         check_en = 0;

  function automatic exp_t mk(logic ir, logic en, logic [7:0] d, logic dn, logic ov, logic bd);
    exp_t e;
    e.ir = ir; e.en = en; e.d = d; e.dn = dn; e.ov = ov; e.bd = bd;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected outputs, one entry per cycle, starting with the cycle in which
  // the first payload byte is presented.
  function automatic void build_seq(input logic [7:0] pl[$], input int r);
    int n  = pl.size();
    int l  = (n > MAXP) ? MAXP : n;
    int rr = (r == 0) ? 1 : r;
    mseq.delete();
    mseq.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < n; i++)
      mseq.push_back(mk(0, 0, 0, 0, (n > MAXP && i == MAXP), 0));
    mseq.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= rr; k++) begin
      mseq.push_back(mk(0, 1, 8'(k), 0, 0, 0));
      for (int j = 0; j < l; j++) mseq.push_back(mk(0, 1, pl[j], 0, 0, 0));
      mseq.push_back(mk(0, 1, TRL, 0, 0, 0));
      for (int g = 0; g < GAP; g++) mseq.push_back(mk(0, 0, 0, 0, 0, 0));
    end
    mseq.push_back(mk(1, 0, 0, 1, 0, 0));
  endfunction

  task automatic run_packet(input logic [7:0] pl[$], input int r, input int busy_c, input int abort_c);
    int n = pl.size();
    build_seq(pl, r);
    if (busy_c >= 0)
      for (int b = 0; b < 3; b++) mseq[busy_c + b + 1].bd = 1'b1;
    foreach (mseq[i]) exp_q.push_back(mseq[i]);
    redundancy = 8'(r);
    for (int c = 0; c < mseq.size(); c++) begin
      if (c == abort_c) begin
        chk("pre_abort_tx_enable", int'(tx_enable), 1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_tx_enable", int'(tx_enable), 0);
        chk("abort_tx_data", int'(tx_data), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        en_in = 1'b0;
        repeat (3) @(posedge clk125MHz);
        #1;
        reset = 1'b1;
        return;
      end
      if (c == n + 2) begin
        chk("first_byte_latency_en", int'(tx_enable), 1);
        chk("first_byte_latency_id", int'(tx_data), 1);
      end
      if (c < n) begin
        en_in   = 1'b1;
        data_in = pl[c];
      end else begin
        en_in   = (busy_c >= 0 && c >= busy_c && c < busy_c + 3);
        data_in = 8'($urandom);
      end
      if (c > 0) redundancy = 8'($urandom);
      @(posedge clk125MHz);
      #1;
    end
  endtask

  always @(negedge clk125MHz) begin
    exp_t e;
    cyc++;
    if (check_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1, 0, 0, 0, 0, 0);
      checks++;
      if ({in_ready, tx_enable, tx_data, done, overflow, busy_drop} !==
          {e.ir, e.en, e.d, e.dn, e.ov, e.bd}) begin
        failures++;
        if (fail_prints < 20)
          $display("FAIL stream cyc=%0d actual ir=%b en=%b d=%h dn=%b ov=%b bd=%b required ir=%b en=%b d=%h dn=%b ov=%b bd=%b",
                   cyc, in_ready, tx_enable, tx_data, done, overflow, busy_drop,
                   e.ir, e.en, e.d, e.dn, e.ov, e.bd);
        fail_prints++;
      end
      if (done) begin
        n_done++;
        chk("in_ready_with_done", int'(in_ready), 1);
      end
      if (overflow) n_ovf++;
      if (busy_drop) n_busy++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p31[$];
    logic [7:0] pl[$];
    int         cnt;

    reset = 1'b0; en_in = 1'b0; data_in = 8'h00; redundancy = 8'h00;
    repeat (3) @(posedge clk125MHz);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_tx_enable", int'(tx_enable), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    chk("reset_pulses", int'({done, overflow, busy_drop}), 0);
    reset = 1'b1;
    check_en = 1'b1;

    for (int i = 0; i < 8; i++) p31.push_back(8'h10 + 8'(i));

    // Pin the model with hand-computed values for the 8-byte, 5-copy packet.
    build_seq(p31, 5);
    chk("model_len", mseq.size(), 121);
    chk("model_first_id", int'(mseq[10].d), 1);
    chk("model_trailer", int'(mseq[19].d), 'hEF);
    chk("model_copy2_id", int'(mseq[32].d), 2);
    chk("model_done_pos", int'(mseq[120].dn), 1);
    cnt = 0;
    foreach (mseq[i]) if (mseq[i].en) cnt++;
    chk("model_tx_bytes", cnt, 50);

    n_done = 0;
    run_packet(p31, 5, -1, -1);
    chk("basic_done_count", n_done, 1);

    pl = '{8'hAA};
    n_done = 0;
    run_packet(pl, 0, -1, -1);
    chk("r0_done_count", n_done, 1);

    pl.delete();
    for (int i = 0; i < MAXP + 3; i++) pl.push_back(8'($urandom));
    n_ovf = 0;
    run_packet(pl, 2, -1, -1);
    chk("overflow_count", n_ovf, 1);

    n_busy = 0;
    run_packet(p31, 2, 13, -1);
    chk("busy_drop_count", n_busy, 3);

    n_done = 0;
    run_packet(p31, 5, -1, 58);
    chk("abort_done_count", n_done, 0);

    pl = '{8'h55, 8'h66};
    run_packet(pl, 1, -1, -1);

    pl = '{8'h3C};
    n_done = 0;
    run_packet(pl, 255, -1, -1);
    chk("r255_done_count", n_done, 1);

    for (int t = 0; t < 5; t++) begin
      int n;
      pl.delete();
      n = $urandom_range(1, MAXP + 6);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_packet(pl, $urandom_range(0, 7), -1, -1);
    end

    repeat (3) @(posedge clk125MHz);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_redundant.md
TX_REDUNDANT -- requirements
Module: tx_redundant

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64: maximum payload bytes buffered per packet.
REQ-002 SHALL have parameter GAP_CYCLES, default 12: idle cycles (tx_enable low) after every transmitted copy.
REQ-003 SHALL have parameter TRAILER, default 8'hEF: byte appended as the last byte of every copy.
REQ-004 SHALL have port clk125MHz  input  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  8: upstream payload byte.
REQ-007 SHALL have port en_in  input  1: payload byte valid; one packet is one contiguous run of en_in high.
REQ-008 SHALL have port redundancy  input  8: number of copies to transmit per packet.
REQ-009 SHALL have port in_ready  output  1: high only when a new packet may start.
REQ-010 SHALL have port tx_data  output  8: transmitted byte, registered.
REQ-011 SHALL have port tx_enable  output  1: tx_data valid, registered.
REQ-012 SHALL have port done  output  1: one-cycle pulse after the last copy's gap completes.
REQ-013 SHALL have port overflow  output  1: one-cycle pulse when payload bytes beyond MAX_PAYLOAD are dropped.
REQ-014 SHALL have port busy_drop  output  1: one-cycle pulse on each en_in-high cycle sampled while in_ready is low and not capturing.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, SEND_ID, SEND_PAYLOAD, SEND_TRAILER, GAP.
REQ-016 SHALL drive in_ready high in IDLE only.
REQ-017 In IDLE, en_in=1 SHALL write data_in to buffer address 0, latch redundancy (0 treated as 1), and enter CAPTURE.
REQ-018 In CAPTURE, each en_in=1 cycle SHALL store data_in at the next address; writes beyond MAX_PAYLOAD bytes SHALL be discarded, with one overflow pulse per packet.
REQ-019 In CAPTURE, en_in=0 SHALL latch length L (1..MAX_PAYLOAD), set copy index to 1, and enter SEND_ID.
REQ-020 Latency: if edge E samples en_in=0 in CAPTURE, then after edge E+1 tx_enable=1 and tx_data=copy index.
REQ-021 Each copy SHALL be exactly L+2 consecutive tx_enable-high cycles: copy index (1..R), payload bytes 0..L-1 in order, then TRAILER.
REQ-022 All copies of a packet SHALL carry identical payload and trailer bytes; only the first byte differs.
REQ-023 After each copy, GAP SHALL hold tx_enable=0 and tx_data=0 for exactly GAP_CYCLES cycles.
REQ-024 After GAP, if copy index < R, SHALL increment the index and enter SEND_ID; otherwise SHALL pulse done and return to IDLE, with in_ready=1 in the same cycle as done.
REQ-025 Changes to redundancy or data_in after the packet start SHALL not affect the packet in flight.
REQ-026 Copy index and byte counters SHALL be 8 and clog2(MAX_PAYLOAD+1) bits wide respectively; R=255 SHALL send 255 copies without wrap.
REQ-027 Whenever tx_enable=0, tx_data SHALL be 8'h00.

Reset
REQ-028 While reset=0, asynchronously: state=IDLE, tx_enable=0, tx_data=0, in_ready=1, done=0, overflow=0, busy_drop=0, counters=0.
REQ-029 A reset mid-copy SHALL abort the packet with no further bytes output; the next packet SHALL start with copy index 1.
REQ-030 Buffer contents need not be cleared by reset.

Verification
REQ-031 Payload 8 bytes 0x10..0x17, redundancy=5 -> five 10-byte frames [k,0x10..0x17,0xEF] for k=1..5, exactly 12 idle cycles after each, one done pulse.
REQ-032 Payload 1 byte 0xAA, redundancy=0 -> one frame [0x01,0xAA,0xEF], then done.
REQ-033 Payload MAX_PAYLOAD+3 bytes -> one overflow pulse; each frame MAX_PAYLOAD+2 bytes containing the first MAX_PAYLOAD bytes.
REQ-034 reset asserted during byte 4 of copy 3 -> tx_enable falls without waiting for a clock edge; after release in_ready=1, and the next packet begins with id 1.
REQ-035 en_in pulsed 3 cycles during SEND_PAYLOAD -> three busy_drop pulses; the output stream is unchanged.
REQ-036 The bench SHALL check first-byte latency per REQ-020 and that in_ready rises in the same cycle as done.
